// File: rtl/snow64_mem_arbiter_if.sv
// Bus bundle between the two cache requesters, the arbiter and the single-port line memory.
// Handshake: every req/valid here is a one-cycle pulse with no ready; fields ride with their pulse (or are held, for out_mem_*).
interface snow64_mem_arbiter_if #(
   parameter int unsigned WIDTH_ADDR = 64,
   parameter int unsigned WIDTH_LINE = 256
);
   logic                  in_icache_req;
   logic [WIDTH_ADDR-1:0] in_icache_addr;
   logic                  out_icache_valid;
   logic [WIDTH_LINE-1:0] out_icache_data;
   logic                  in_dcache_req;
   logic [WIDTH_ADDR-1:0] in_dcache_addr;
   logic                  in_dcache_we;
   logic [WIDTH_LINE-1:0] in_dcache_wdata;
   logic                  out_dcache_valid;
   logic [WIDTH_LINE-1:0] out_dcache_data;
   logic                  out_mem_req;
   logic [WIDTH_ADDR-1:0] out_mem_addr;
   logic                  out_mem_we;
   logic [WIDTH_LINE-1:0] out_mem_wdata;
   logic                  in_mem_valid;
   logic [WIDTH_LINE-1:0] in_mem_rdata;
   logic                  out_busy;

   modport slave (
      input  in_icache_req, in_icache_addr,
      input  in_dcache_req, in_dcache_addr, in_dcache_we, in_dcache_wdata,
      input  in_mem_valid, in_mem_rdata,
      output out_icache_valid, out_icache_data,
      output out_dcache_valid, out_dcache_data,
      output out_mem_req, out_mem_addr, out_mem_we, out_mem_wdata,
      output out_busy
   );

   modport master (
      output in_icache_req, in_icache_addr,
      output in_dcache_req, in_dcache_addr, in_dcache_we, in_dcache_wdata,
      output in_mem_valid, in_mem_rdata,
      input  out_icache_valid, out_icache_data,
      input  out_dcache_valid, out_dcache_data,
      input  out_mem_req, out_mem_addr, out_mem_we, out_mem_wdata,
      input  out_busy
   );
endinterface

// File: rtl/snow64_mem_arbiter.sv
// Round-robin arbiter sharing one line memory between icache and dcache, one transaction at a time.
// Requests are latched into per-requester pending slots and granted from the idle state one edge later.
module snow64_mem_arbiter #(
   parameter int unsigned WIDTH_ADDR = 64,
   parameter int unsigned WIDTH_LINE = 256
) (
   input  logic                clk,
   input  logic                rst_n,
   snow64_mem_arbiter_if.slave bus,
   output logic                out_dbg_state
);
   typedef enum logic {StIdle = 1'b0, StWaitForMem = 1'b1} state_t;
   localparam logic GntIcache = 1'b0;
   localparam logic GntDcache = 1'b1;

   state_t                state_q, state_d;
   logic                  i_pend_q, i_pend_d;
   logic [WIDTH_ADDR-1:0] i_addr_q, i_addr_d;
   logic                  d_pend_q, d_pend_d;
   logic [WIDTH_ADDR-1:0] d_addr_q, d_addr_d;
   logic                  d_we_q, d_we_d;
   logic [WIDTH_LINE-1:0] d_wdata_q, d_wdata_d;
   logic                  last_gnt_q, last_gnt_d;
   logic                  mem_req_q, mem_req_d;
   logic [WIDTH_ADDR-1:0] mem_addr_q, mem_addr_d;
   logic                  mem_we_q, mem_we_d;
   logic [WIDTH_LINE-1:0] mem_wdata_q, mem_wdata_d;
   logic                  i_valid_q, i_valid_d;
   logic [WIDTH_LINE-1:0] i_data_q, i_data_d;
   logic                  d_valid_q, d_valid_d;
   logic [WIDTH_LINE-1:0] d_data_q, d_data_d;
   logic                  busy, grant_i, grant_d, done_i, done_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:       if (i_pend_q || d_pend_q) state_d = StWaitForMem;
         StWaitForMem: if (bus.in_mem_valid)     state_d = StIdle;
         default:      state_d = StIdle;
      endcase
   end

   // last_gnt_q doubles as the current grantee while a transaction is outstanding.
   always_comb begin
      busy    = (state_q == StWaitForMem);
      grant_i = (state_q == StIdle) && i_pend_q && (!d_pend_q || (last_gnt_q == GntDcache));
      grant_d = (state_q == StIdle) && d_pend_q && !grant_i;
      done_i  = busy && bus.in_mem_valid && (last_gnt_q == GntIcache);
      done_d  = busy && bus.in_mem_valid && (last_gnt_q == GntDcache);
   end

   always_comb begin
      i_pend_d    = i_pend_q;
      i_addr_d    = i_addr_q;
      d_pend_d    = d_pend_q;
      d_addr_d    = d_addr_q;
      d_we_d      = d_we_q;
      d_wdata_d   = d_wdata_q;
      last_gnt_d  = last_gnt_q;
      mem_req_d   = grant_i || grant_d;
      mem_addr_d  = mem_addr_q;
      mem_we_d    = mem_we_q;
      mem_wdata_d = mem_wdata_q;
      i_valid_d   = done_i;
      d_valid_d   = done_d;
      i_data_d    = i_data_q;
      d_data_d    = d_data_q;

      if (bus.in_icache_req && !i_pend_q) begin
         i_pend_d = 1'b1;
         i_addr_d = bus.in_icache_addr;
      end
      if (bus.in_dcache_req && !d_pend_q) begin
         d_pend_d  = 1'b1;
         d_addr_d  = bus.in_dcache_addr;
         d_we_d    = bus.in_dcache_we;
         d_wdata_d = bus.in_dcache_wdata;
      end

      if (grant_i) begin
         last_gnt_d  = GntIcache;
         mem_addr_d  = i_addr_q;
         mem_we_d    = 1'b0;
         mem_wdata_d = '0;
      end else if (grant_d) begin
         last_gnt_d  = GntDcache;
         mem_addr_d  = d_addr_q;
         mem_we_d    = d_we_q;
         mem_wdata_d = d_wdata_q;
      end

      if (done_i) begin
         i_pend_d = 1'b0;
         i_data_d = bus.in_mem_rdata;
      end
      // A write completion leaves the dcache data output untouched.
      if (done_d) begin
         d_pend_d = 1'b0;
         if (!mem_we_q) d_data_d = bus.in_mem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_pend_q    <= 1'b0;
         i_addr_q    <= '0;
         d_pend_q    <= 1'b0;
         d_addr_q    <= '0;
         d_we_q      <= 1'b0;
         d_wdata_q   <= '0;
         last_gnt_q  <= GntDcache;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         i_valid_q   <= 1'b0;
         i_data_q    <= '0;
         d_valid_q   <= 1'b0;
         d_data_q    <= '0;
      end else begin
         i_pend_q    <= i_pend_d;
         i_addr_q    <= i_addr_d;
         d_pend_q    <= d_pend_d;
         d_addr_q    <= d_addr_d;
         d_we_q      <= d_we_d;
         d_wdata_q   <= d_wdata_d;
         last_gnt_q  <= last_gnt_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         i_valid_q   <= i_valid_d;
         i_data_q    <= i_data_d;
         d_valid_q   <= d_valid_d;
         d_data_q    <= d_data_d;
      end
   end

   assign bus.out_icache_valid = i_valid_q;
   assign bus.out_icache_data  = i_data_q;
   assign bus.out_dcache_valid = d_valid_q;
   assign bus.out_dcache_data  = d_data_q;
   assign bus.out_mem_req      = mem_req_q;
   assign bus.out_mem_addr     = mem_addr_q;
   assign bus.out_mem_we       = mem_we_q;
   assign bus.out_mem_wdata    = mem_wdata_q;
   assign bus.out_busy         = busy;
   assign out_dbg_state        = state_q;
endmodule

// File: tb/tb_snow64_mem_arbiter.sv
// Directed bench for snow64_mem_arbiter: inputs driven and outputs sampled on the falling clock edge.
module tb_snow64_mem_arbiter;
  localparam int WA = 64;
  localparam int WL = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dbg_state;
  int checks = 0;
  int failures = 0;
  logic [WL-1:0] exp_i_data, exp_d_data, rd;
  logic [WA-1:0] exp_q[$];
  logic [WA-1:0] exp_addr;

  snow64_mem_arbiter_if #(.WIDTH_ADDR(WA), .WIDTH_LINE(WL)) bus ();

  snow64_mem_arbiter #(.WIDTH_ADDR(WA), .WIDTH_LINE(WL)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .out_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [WL-1:0] obs, input logic [WL-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_icache_req = 1'b0;
    bus.in_icache_addr = '0;
    bus.in_dcache_req = 1'b0;
    bus.in_dcache_addr = '0;
    bus.in_dcache_we = 1'b0;
    bus.in_dcache_wdata = '0;
    bus.in_mem_valid = 1'b0;
    bus.in_mem_rdata = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ivalid"}, bus.out_icache_valid, 0);
    chk({tag, "_idata"}, bus.out_icache_data, 0);
    chk({tag, "_dvalid"}, bus.out_dcache_valid, 0);
    chk({tag, "_ddata"}, bus.out_dcache_data, 0);
    chk({tag, "_memreq"}, bus.out_mem_req, 0);
    chk({tag, "_memaddr"}, bus.out_mem_addr, 0);
    chk({tag, "_memwe"}, bus.out_mem_we, 0);
    chk({tag, "_memwdata"}, bus.out_mem_wdata, 0);
    chk({tag, "_busy"}, bus.out_busy, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  task automatic wait_mem_req(input string tag);
    int n = 0;
    while (!bus.out_mem_req && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_memreq_seen"}, bus.out_mem_req, 1);
  endtask

  task automatic complete(input logic [WL-1:0] data);
    bus.in_mem_valid = 1'b1;
    bus.in_mem_rdata = data;
    tick();
    bus.in_mem_valid = 1'b0;
  endtask

  task automatic count_mem_req(input string tag, input int cycles);
    int cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.out_mem_req) cnt++;
    end
    chk({tag, "_extra_memreq"}, cnt, 0);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single icache read, memory answers 3 cycles after the request pulse.
    bus.in_icache_req = 1'b1;
    bus.in_icache_addr = 64'h1000;
    tick();
    bus.in_icache_req = 1'b0;
    chk("ird_no_same_edge_grant", bus.out_mem_req, 0);
    tick();
    chk("ird_memreq", bus.out_mem_req, 1);
    chk("ird_addr", bus.out_mem_addr, 64'h1000);
    chk("ird_we", bus.out_mem_we, 0);
    chk("ird_busy", bus.out_busy, 1);
    chk("ird_state", dbg_state, 1);
    tick();
    chk("ird_memreq_one_cycle", bus.out_mem_req, 0);
    tick();
    tick();
    chk("ird_no_early_valid", bus.out_icache_valid, 0);
    exp_i_data = {8{32'hAAAAAAAA}};
    complete(exp_i_data);
    chk("ird_valid", bus.out_icache_valid, 1);
    chk("ird_data", bus.out_icache_data, exp_i_data);
    chk("ird_busy_clear", bus.out_busy, 0);
    tick();
    chk("ird_valid_one_cycle", bus.out_icache_valid, 0);
    chk("ird_data_hold", bus.out_icache_data, exp_i_data);

    // Tie right after reset: icache first, dcache after one idle edge.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.in_icache_req = 1'b1;
    bus.in_icache_addr = 64'h100;
    bus.in_dcache_req = 1'b1;
    bus.in_dcache_addr = 64'h200;
    bus.in_dcache_we = 1'b0;
    tick();
    idle_inputs();
    chk("tie_no_grant_yet", bus.out_mem_req, 0);
    tick();
    chk("tie_first_addr", bus.out_mem_addr, 64'h100);
    chk("tie_first_req", bus.out_mem_req, 1);
    exp_i_data = {8{32'h11111111}};
    complete(exp_i_data);
    chk("tie_ivalid", bus.out_icache_valid, 1);
    chk("tie_idata", bus.out_icache_data, exp_i_data);
    chk("tie_dvalid_quiet", bus.out_dcache_valid, 0);
    chk("tie_no_grant_on_completion", bus.out_mem_req, 0);
    tick();
    chk("tie_second_req", bus.out_mem_req, 1);
    chk("tie_second_addr", bus.out_mem_addr, 64'h200);
    chk("tie_second_we", bus.out_mem_we, 0);
    exp_d_data = {8{32'hBBBBBBBB}};
    complete(exp_d_data);
    chk("tie_dvalid", bus.out_dcache_valid, 1);
    chk("tie_ddata", bus.out_dcache_data, exp_d_data);
    chk("tie_idata_hold", bus.out_icache_data, exp_i_data);

    // Three back-to-back tie rounds; grant addresses come from the expected queue.
    for (int r = 0; r < 3; r++) begin
      bus.in_icache_req = 1'b1;
      bus.in_icache_addr = 64'h3000 + 64'(r);
      bus.in_dcache_req = 1'b1;
      bus.in_dcache_addr = 64'h4000 + 64'(r);
      exp_q.push_back(64'h3000 + 64'(r));
      exp_q.push_back(64'h4000 + 64'(r));
      tick();
      idle_inputs();
      for (int k = 0; k < 2; k++) begin
        wait_mem_req("rr");
        exp_addr = exp_q.pop_front();
        chk("rr_addr", bus.out_mem_addr, exp_addr);
        rd = {8{32'(r * 16 + k + 1)}};
        complete(rd);
        if (k == 0) begin
          exp_i_data = rd;
          chk("rr_ivalid", bus.out_icache_valid, 1);
          chk("rr_dvalid_quiet", bus.out_dcache_valid, 0);
          chk("rr_idata", bus.out_icache_data, exp_i_data);
        end else begin
          exp_d_data = rd;
          chk("rr_dvalid", bus.out_dcache_valid, 1);
          chk("rr_ivalid_quiet", bus.out_icache_valid, 0);
          chk("rr_ddata", bus.out_dcache_data, exp_d_data);
        end
      end
    end
    chk("rr_queue_drained", exp_q.size(), 0);

    // dcache line write: data output must not change.
    tick();
    bus.in_dcache_req = 1'b1;
    bus.in_dcache_addr = 64'h2040;
    bus.in_dcache_we = 1'b1;
    bus.in_dcache_wdata = {8{32'h55555555}};
    tick();
    idle_inputs();
    tick();
    chk("wr_memreq", bus.out_mem_req, 1);
    chk("wr_addr", bus.out_mem_addr, 64'h2040);
    chk("wr_we", bus.out_mem_we, 1);
    chk("wr_wdata", bus.out_mem_wdata, {8{32'h55555555}});
    complete({8{32'hDEADBEEF}});
    chk("wr_dvalid", bus.out_dcache_valid, 1);
    chk("wr_ddata_kept", bus.out_dcache_data, exp_d_data);
    tick();
    chk("wr_dvalid_one_cycle", bus.out_dcache_valid, 0);

    // Repeated icache req while pending is dropped, also when granted.
    bus.in_icache_req = 1'b1;
    bus.in_icache_addr = 64'h5000;
    tick();
    bus.in_icache_addr = 64'h6000;
    tick();
    bus.in_icache_req = 1'b0;
    chk("dup_memreq", bus.out_mem_req, 1);
    chk("dup_addr", bus.out_mem_addr, 64'h5000);
    bus.in_icache_req = 1'b1;
    bus.in_icache_addr = 64'h7000;
    tick();
    idle_inputs();
    exp_i_data = {8{32'h77777777}};
    complete(exp_i_data);
    chk("dup_ivalid", bus.out_icache_valid, 1);
    chk("dup_idata", bus.out_icache_data, exp_i_data);
    count_mem_req("dup", 10);

    // Tie with icache granted last: dcache wins; dcache req on an icache completion edge is kept.
    bus.in_icache_req = 1'b1;
    bus.in_icache_addr = 64'h8000;
    bus.in_dcache_req = 1'b1;
    bus.in_dcache_addr = 64'h9000;
    bus.in_dcache_we = 1'b0;
    tick();
    idle_inputs();
    tick();
    chk("rr2_first_addr", bus.out_mem_addr, 64'h9000);
    exp_d_data = {8{32'h99999999}};
    complete(exp_d_data);
    chk("rr2_dvalid", bus.out_dcache_valid, 1);
    tick();
    chk("rr2_second_addr", bus.out_mem_addr, 64'h8000);
    chk("rr2_second_req", bus.out_mem_req, 1);
    bus.in_dcache_req = 1'b1;
    bus.in_dcache_addr = 64'hA000;
    exp_i_data = {8{32'h88888888}};
    complete(exp_i_data);
    idle_inputs();
    chk("cap_ivalid", bus.out_icache_valid, 1);
    tick();
    chk("cap_memreq", bus.out_mem_req, 1);
    chk("cap_addr", bus.out_mem_addr, 64'hA000);
    exp_d_data = {8{32'hCCCCCCCC}};
    complete(exp_d_data);
    chk("cap_dvalid", bus.out_dcache_valid, 1);
    chk("cap_ddata", bus.out_dcache_data, exp_d_data);

    // Stray memory completion while idle.
    tick();
    bus.in_mem_valid = 1'b1;
    bus.in_mem_rdata = {8{32'h12345678}};
    tick();
    idle_inputs();
    chk("idle_mv_ivalid", bus.out_icache_valid, 0);
    chk("idle_mv_dvalid", bus.out_dcache_valid, 0);
    chk("idle_mv_busy", bus.out_busy, 0);
    chk("idle_mv_idata", bus.out_icache_data, exp_i_data);
    count_mem_req("idle_mv", 3);

    // Reset in the middle of a transaction, then a late completion.
    bus.in_icache_req = 1'b1;
    bus.in_icache_addr = 64'hB000;
    tick();
    idle_inputs();
    wait_mem_req("rst_mid");
    tick();
    chk("rst_mid_busy_before", bus.out_busy, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    tick();
    rst_n = 1'b1;
    tick();
    bus.in_mem_valid = 1'b1;
    bus.in_mem_rdata = {8{32'hFFFFFFFF}};
    tick();
    idle_inputs();
    chk("late_mv_ivalid", bus.out_icache_valid, 0);
    chk("late_mv_idata", bus.out_icache_data, 0);
    chk("late_mv_busy", bus.out_busy, 0);
    count_mem_req("late_mv", 5);
    chk("late_mv_busy_after", bus.out_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
